// File: rtl/la_pkg.sv
// Shared analyzer definitions: buffer geometry and the readout FSM state encoding.
// CKSUM exists only when LA_READOUT_CHECKSUM_EN is defined.
package la_pkg;

  localparam int LA_DEPTH_LOG2 = 9;
  localparam int LA_DATA_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    LOAD   = 3'd2,
    SEND   = 3'd3,
`ifdef LA_READOUT_CHECKSUM_EN
    CKSUM  = 3'd4,
`endif
    FINISH = 3'd5
  } la_state_t;

endpackage

// File: rtl/la_byte_serializer.sv
// Turns one loaded word into a valid/ready byte stream, LSB first.
// load_byte sends only the low byte (used for the trailing checksum when LA_READOUT_CHECKSUM_EN is defined).
module la_byte_serializer #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  load_byte,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  last_xfer
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BCW    = $clog2(NBYTES + 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BCW-1:0]        byte_cnt;
  logic [BCW-1:0]        byte_last;
  logic                  xfer;

  assign xfer      = tx_valid & tx_ready;
  assign last_xfer = xfer && (byte_cnt == byte_last);
  assign tx_data   = shift_reg[7:0];

  // A load on the same edge as the final transfer wins, keeping tx_valid high back-to-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
      byte_last <= '0;
      tx_valid  <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      byte_cnt  <= '0;
      byte_last <= load_byte ? '0 : BCW'(NBYTES - 1);
      tx_valid  <= 1'b1;
    end else if (xfer) begin
      shift_reg <= shift_reg >> 8;
      byte_cnt  <= byte_cnt + BCW'(1);
      if (last_xfer) tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/la_readout_streamer.sv
// Dumps the halted logic-analyzer buffer, oldest sample first, as a byte stream.
// Define LA_READOUT_CHECKSUM_EN to append an XOR checksum byte.
module la_readout_streamer
  import la_pkg::*;
#(
  parameter int DATA_WIDTH = LA_DATA_WIDTH,
  parameter int DEPTH_LOG2 = LA_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture_done,
  input  logic [DEPTH_LOG2-1:0] capture_start,
  input  logic                  start,
  output logic                  busy,
  output logic [DEPTH_LOG2-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  la_state_t             state, state_next;
  logic [DEPTH_LOG2-1:0] base;
  logic [DEPTH_LOG2:0]   count, count_inc;
  logic                  accept, terminal, last_xfer;
  logic                  ser_load, ser_load_byte;
  logic [DATA_WIDTH-1:0] ser_data;

  assign accept    = (state == IDLE) && start && capture_done;
  assign count_inc = count + (DEPTH_LOG2 + 1)'(1);
  assign terminal  = count_inc[DEPTH_LOG2];
  assign busy      = (state != IDLE);

`ifdef LA_READOUT_CHECKSUM_EN
  logic [7:0] checksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (state == SEND && tx_valid && tx_ready) begin
      checksum <= checksum ^ tx_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    ser_load      = 1'b0;
    ser_load_byte = 1'b0;
    ser_data      = read_data;
    case (state)
      IDLE:   if (accept) state_next = ADDR;
      ADDR:   state_next = LOAD;
      LOAD: begin
        ser_load   = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (last_xfer) begin
          if (terminal) begin
`ifdef LA_READOUT_CHECKSUM_EN
            // The final data byte is leaving this cycle, so fold it in before loading.
            ser_load      = 1'b1;
            ser_load_byte = 1'b1;
            ser_data      = {{(DATA_WIDTH - 8){1'b0}}, checksum ^ tx_data};
            state_next    = CKSUM;
`else
            state_next    = FINISH;
`endif
          end else begin
            state_next = ADDR;
          end
        end
      end
`ifdef LA_READOUT_CHECKSUM_EN
      CKSUM:  if (last_xfer) state_next = FINISH;
`endif
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base      <= '0;
      count     <= '0;
      read_addr <= '0;
    end else if (accept) begin
      base      <= capture_start;
      count     <= '0;
      read_addr <= capture_start;
    end else if (state == SEND && last_xfer) begin
      count <= count_inc;
      if (!terminal) read_addr <= base + count_inc[DEPTH_LOG2-1:0];
    end
  end

  la_byte_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_byte (ser_load_byte),
    .load_data (ser_data),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .last_xfer (last_xfer)
  );

endmodule

// File: tb/tb_la_readout_streamer.sv
// Scoreboard bench: a buffer model predicts the byte stream per dump, a monitor checks every transfer.
// Honours LA_READOUT_CHECKSUM_EN when it is defined for the build.
module tb_la_readout_streamer;

  localparam int DW     = 128;
  localparam int DL     = 9;
  localparam int N      = 512;
  localparam int NB     = DW / 8;
  localparam int LIMIT  = 60000;
`ifdef LA_READOUT_CHECKSUM_EN
  localparam int EXTRA  = 1;
`else
  localparam int EXTRA  = 0;
`endif
  localparam int DUMP_CYCLES = N * (2 + NB) + 1 + EXTRA;
  localparam int DUMP_BYTES  = N * NB + EXTRA;

  logic          clk = 1'b0;
  logic          reset;
  logic          capture_done;
  logic [DL-1:0] capture_start;
  logic          start;
  logic          busy;
  logic [DL-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  logic [DW-1:0] mem [N];
  logic [7:0]    exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            nbytes = 0;
  bit            hold_pending = 0;
  logic [7:0]    hold_data;

  always #5 clk = ~clk;

  la_readout_streamer dut (
    .clk           (clk),
    .reset         (reset),
    .capture_done  (capture_done),
    .capture_start (capture_start),
    .start         (start),
    .busy          (busy),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  // Analyzer buffer: synchronous read, one clock of latency.
  always @(posedge clk) read_data <= mem[read_addr];

  // Monitor: a byte moves on the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        checks++;
        if (!(tx_valid === 1'b1 && tx_data === hold_data)) begin
          errors++;
          $display("FAIL hold_stable: valid=%b data=%02h, required valid=1 data=%02h", tx_valid, tx_data, hold_data);
        end
      end
      if (tx_valid === 1'b1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL valid_while_idle: busy=%b, required 1", busy);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %02h, required no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL byte_%0d: got %02h, required %02h", nbytes, tx_data, e);
          end
        end
        nbytes++;
      end
      hold_pending = (tx_valid === 1'b1) && (tx_ready === 1'b0);
      hold_data    = tx_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Expected stream: every sample oldest-first, bytes LSB first, optional XOR trailer.
  task automatic push_expected(input int cs);
    logic [7:0] x;
    logic [7:0] b;
    logic [DW-1:0] w;
    x = 8'h00;
    for (int i = 0; i < N; i++) begin
      w = mem[(cs + i) % N];
      for (int k = 0; k < NB; k++) begin
        b = w[8*k +: 8];
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
`ifdef LA_READOUT_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic begin_dump(input int cs);
    exp_q.delete();
    push_expected(cs);
    nbytes        = 0;
    capture_done  = 1'b1;
    capture_start = DL'(cs);
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_dump(input string name, input int cs, input bit rnd_ready,
                          input bit disturb, input bit check_time);
    int cycles;
    begin_dump(cs);
    cycles = 0;
    do begin
      tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (disturb) begin
        start = (cycles % 997 == 5) && (cycles < 8000);
        if (cycles == 3000) capture_done = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end while (busy && cycles < LIMIT);
    start    = 1'b0;
    tx_ready = 1'b1;
    if (cycles >= LIMIT) begin
      errors++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles", name, busy, cycles);
    end
    if (check_time) check({name, "_cycles"}, cycles, DUMP_CYCLES);
    check({name, "_bytes"}, nbytes, DUMP_BYTES);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_valid_end"}, tx_valid, 0);
  endtask

  initial begin
    int cs;
    int waited;
    reset         = 1'b1;
    capture_done  = 1'b0;
    capture_start = '0;
    start         = 1'b0;
    tx_ready      = 1'b1;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_addr", read_addr, 0);
    reset = 1'b0;

    // Wrapping dump at full throughput with a known first word.
    mem[9'h1F0] = 128'h0F0E0D0C0B0A09080706050403020100;
    run_dump("full", 9'h1F0, 1'b0, 1'b0, 1'b1);

    // Back-pressure, stray starts and capture_done falling mid-dump.
    fill_random();
    cs = $urandom_range(0, N - 1);
    run_dump("rand", cs, 1'b1, 1'b1, 1'b0);

    // start without a finished capture is ignored.
    capture_done = 1'b0;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("nodone_busy", busy, 0);
      check("nodone_valid", tx_valid, 0);
      @(posedge clk);
      #1;
    end

    // Reset mid-stream, then a fresh dump replays from byte 0.
    cs = $urandom_range(0, N - 1);
    begin_dump(cs);
    waited = 0;
    while (nbytes < 100 && waited < 1000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (nbytes < 100) begin
      errors++;
      $display("FAIL midreset_wait: %0d bytes after %0d cycles, required 100", nbytes, waited);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_valid", tx_valid, 0);
    check("midreset_data", tx_data, 0);
    check("midreset_addr", read_addr, 0);
    run_dump("replay", cs, 1'b0, 1'b0, 1'b1);

`ifdef LA_READOUT_CHECKSUM_EN
    for (int i = 0; i < N; i++) mem[i] = {NB{8'hA5}};
    run_dump("cksum_a5", 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[37] = 128'h3C << 40;
    run_dump("cksum_3c", 5, 1'b1, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
